z3_master_seq: RTL and testbench

Zorro III bus-master cycle sequencer for the A4092. It sits between the NCR 53C710 local master interface and the Zorro III bus. It arbitrates for the bus on the 710's request, runs one Zorro III master cycle per 710 transfer, and terminates the 710 cycle with STERM_n or TEA_n. Its BMASTER output is the signal the slave/target logic uses to suppress slave decoding and to switch buffer direction.

---
 rtl/z3_master_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_z3_master_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/z3_master_seq.sv
// ---------------------------------------------------------------------------
// z3_master_seq
//
// Zorro III bus-master cycle sequencer for the A4092. It sits between the
// NCR 53C710 local master port and the Zorro III bus. It requests the bus
// on behalf of the 710 and runs one Zorro III full cycle for each 710
// transfer. Each 710 cycle ends with either STERM_n (normal) or TEA_n
// (bus error / timeout).
//
// Parameters
//   TIMEOUT_CYCLES   CLK cycles allowed for an acknowledge before a forced
//                    error termination (8..255)
//   RECOVERY_CYCLES  minimum CLK cycles spent recovering after a
//                    termination before the next cycle may start (1..7)
//
// Ports
//   CLK, IORST_n     system clock; asynchronous active-low reset
//   SBR_n / SBG_n    710 bus request (async, synchronised) / grant to 710
//   SAS_n            710 transfer strobe (synchronised)
//   SREAD, SSIZ, SA  710 direction, transfer size, address bits [1:0]
//   BR_n / BG_n      Zorro III bus request / grant (grant synchronised)
//   FCS_n            Zorro III full cycle strobe
//   DS_n[3:0]        byte data strobes, DS_n[3] = offset 0 (D31:24)
//   READ_O, DOE_O    Zorro READ and data output enable
//   DTACK_n, BERR_n  target acknowledge / bus error (synchronised)
//   STERM_n, TEA_n   one-cycle termination pulses to the 710
//   BMASTER          high while this board owns the Zorro bus
// ---------------------------------------------------------------------------
module z3_master_seq #(
  parameter int TIMEOUT_CYCLES  = 255,
  parameter int RECOVERY_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       IORST_n,
  input  logic       SBR_n,
  output logic       SBG_n,
  input  logic       SAS_n,
  input  logic       SREAD,
  input  logic [1:0] SSIZ,
  input  logic [1:0] SA,
  output logic       BR_n,
  input  logic       BG_n,
  output logic       FCS_n,
  output logic [3:0] DS_n,
  output logic       READ_O,
  output logic       DOE_O,
  input  logic       DTACK_n,
  input  logic       BERR_n,
  output logic       STERM_n,
  output logic       TEA_n,
  output logic       BMASTER
);

  localparam logic [7:0] TO_LIM  = 8'(TIMEOUT_CYCLES);
  localparam logic [2:0] REC_LIM = 3'(RECOVERY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_OWN,
    S_ADDR,
    S_DATA,
    S_TERM,
    S_RECOVER,
    S_RELEASE
  } state_t;

  // Synchroniser bit positions within the packed sync vectors.
  localparam int IX_SBR   = 4;
  localparam int IX_SAS   = 3;
  localparam int IX_BG    = 2;
  localparam int IX_DTACK = 1;
  localparam int IX_BERR  = 0;

  logic [4:0] sync1_q, sync2_q;
  logic       sbr_s, sas_s, bg_s, dtack_s, berr_s;

  state_t     state_q, state_d;
  logic       err_q, err_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [2:0] rec_cnt_q, rec_cnt_d;
  logic       rd_q, rd_d;
  logic [1:0] siz_q, siz_d;
  logic [1:0] sa_q, sa_d;

  // Byte-lane mask for a transfer starting at offset sa of the given size.
  // Bit 3 is offset 0. Lanes past offset 3 are clipped: a transfer never
  // spills into the next longword on this bus.
  function automatic logic [3:0] lane_mask(input logic [1:0] sa,
                                           input logic [1:0] siz);
    logic [2:0] sa3;
    logic [2:0] n;
    logic [2:0] end_off;
    logic [3:0] m;
    sa3     = {1'b0, sa};
    n       = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
    end_off = sa3 + n;
    m[3]    = (sa3 <= 3'd0) && (3'd0 < end_off);
    m[2]    = (sa3 <= 3'd1) && (3'd1 < end_off);
    m[1]    = (sa3 <= 3'd2) && (3'd2 < end_off);
    m[0]    = (sa3 <= 3'd3) && (3'd3 < end_off);
    return m;
  endfunction

  assign sbr_s   = sync2_q[IX_SBR];
  assign sas_s   = sync2_q[IX_SAS];
  assign bg_s    = sync2_q[IX_BG];
  assign dtack_s = sync2_q[IX_DTACK];
  assign berr_s  = sync2_q[IX_BERR];

  // State register and synchronisers; everything resets to the inactive
  // (high) level so a reset cannot fake a request or acknowledge.
  always_ff @(posedge CLK or negedge IORST_n) begin
    if (!IORST_n) begin
      sync1_q   <= 5'b11111;
      sync2_q   <= 5'b11111;
      state_q   <= S_IDLE;
      err_q     <= 1'b0;
      to_cnt_q  <= 8'd0;
      rec_cnt_q <= 3'd0;
    end else begin
      sync1_q   <= {SBR_n, SAS_n, BG_n, DTACK_n, BERR_n};
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      err_q     <= err_d;
      to_cnt_q  <= to_cnt_d;
      rec_cnt_q <= rec_cnt_d;
    end
  end

  // Transfer attributes captured when the 710 strobe is accepted. They are
  // only observed in ADDR/DATA, so they need no reset.
  always_ff @(posedge CLK) begin
    rd_q  <= rd_d;
    siz_q <= siz_d;
    sa_q  <= sa_d;
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    to_cnt_d  = to_cnt_q;
    rec_cnt_d = rec_cnt_q;
    rd_d      = rd_q;
    siz_d     = siz_q;
    sa_d      = sa_q;
    case (state_q)
      S_IDLE: begin
        if (!sbr_s) state_d = S_REQ;
      end
      S_REQ: begin
        if (!bg_s) state_d = S_OWN;
      end
      S_OWN: begin
        // A pending release beats a new strobe; a withdrawn grant is
        // deliberately ignored, ownership ends only via SBR_n.
        if (sbr_s) begin
          state_d = S_RELEASE;
        end else if (!sas_s) begin
          rd_d    = SREAD;
          siz_d   = SSIZ;
          sa_d    = SA;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        to_cnt_d = 8'd0;
        state_d  = S_DATA;
      end
      S_DATA: begin
        to_cnt_d = to_cnt_q + 8'd1;
        // Error outranks acknowledge when both arrive together.
        if (!berr_s) begin
          err_d   = 1'b1;
          state_d = S_TERM;
        end else if (!dtack_s) begin
          err_d   = 1'b0;
          state_d = S_TERM;
        end else if (to_cnt_q == TO_LIM) begin
          err_d   = 1'b1;
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        rec_cnt_d = 3'd0;
        state_d   = S_RECOVER;
      end
      S_RECOVER: begin
        // Stay at least RECOVERY_CYCLES and until the target has let go of
        // DTACK_n, so a stale acknowledge cannot end the next cycle.
        if (rec_cnt_q != REC_LIM) rec_cnt_d = rec_cnt_q + 3'd1;
        if ((rec_cnt_q == REC_LIM) && dtack_s) state_d = S_OWN;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the state register alone, so the asynchronous
  // reset forces every output inactive immediately.
  always_comb begin
    BR_n    = 1'b1;
    SBG_n   = 1'b1;
    BMASTER = 1'b0;
    FCS_n   = 1'b1;
    DS_n    = 4'b1111;
    READ_O  = 1'b0;
    DOE_O   = 1'b0;
    STERM_n = 1'b1;
    TEA_n   = 1'b1;
    case (state_q)
      S_REQ: begin
        BR_n = 1'b0;
      end
      S_OWN, S_RECOVER: begin
        BR_n    = 1'b0;
        SBG_n   = 1'b0;
        BMASTER = 1'b1;
      end
      S_ADDR: begin
        BR_n    = 1'b0;
        SBG_n   = 1'b0;
        BMASTER = 1'b1;
        FCS_n   = 1'b0;
        READ_O  = rd_q;
      end
      S_DATA: begin
        BR_n    = 1'b0;
        SBG_n   = 1'b0;
        BMASTER = 1'b1;
        FCS_n   = 1'b0;
        READ_O  = rd_q;
        DOE_O   = 1'b1;
        DS_n    = ~lane_mask(sa_q, siz_q);
      end
      S_TERM: begin
        BR_n    = 1'b0;
        SBG_n   = 1'b0;
        BMASTER = 1'b1;
        STERM_n = err_q;
        TEA_n   = ~err_q;
      end
      default: begin
        BR_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_z3_master_seq.sv
// ---------------------------------------------------------------------------
// tb_z3_master_seq
//
// Drives arbitration and transfer sequences into z3_master_seq and compares
// the observed timing and strobes against cycle numbers and lane masks
// derived directly from the bus rules (latencies, priorities, recovery).
// ---------------------------------------------------------------------------
module tb_z3_master_seq;

  localparam int TO  = 16;
  localparam int REC = 2;
  localparam logic [11:0] RST_OUTS = 12'hFF8;

  logic       CLK, IORST_n, SBR_n, SBG_n, SAS_n, SREAD;
  logic [1:0] SSIZ, SA;
  logic       BR_n, BG_n, FCS_n;
  logic [3:0] DS_n;
  logic       READ_O, DOE_O, DTACK_n, BERR_n, STERM_n, TEA_n, BMASTER;
  logic [11:0] outs;

  int cyc   = 0;
  int n_chk = 0;
  int n_err = 0;

  z3_master_seq #(
    .TIMEOUT_CYCLES (TO),
    .RECOVERY_CYCLES(REC)
  ) dut (
    .CLK    (CLK),
    .IORST_n(IORST_n),
    .SBR_n  (SBR_n),
    .SBG_n  (SBG_n),
    .SAS_n  (SAS_n),
    .SREAD  (SREAD),
    .SSIZ   (SSIZ),
    .SA     (SA),
    .BR_n   (BR_n),
    .BG_n   (BG_n),
    .FCS_n  (FCS_n),
    .DS_n   (DS_n),
    .READ_O (READ_O),
    .DOE_O  (DOE_O),
    .DTACK_n(DTACK_n),
    .BERR_n (BERR_n),
    .STERM_n(STERM_n),
    .TEA_n  (TEA_n),
    .BMASTER(BMASTER)
  );

  assign outs = {BR_n, SBG_n, FCS_n, STERM_n, TEA_n, DS_n, READ_O, DOE_O, BMASTER};

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Expected DS_n: walk the N bytes starting at SA and drop those past
  // offset 3; offset k drives DS_n[3-k] low.
  function automatic logic [3:0] exp_ds(input logic [1:0] sa, input logic [1:0] siz);
    logic [3:0] ds;
    int n, off;
    ds = 4'hF;
    n  = (siz == 2'b00) ? 4 : int'(siz);
    for (int k = 0; k < n; k++) begin
      off = int'(sa) + k;
      if (off <= 3) ds = ds & ~(4'(1) << (3 - off));
    end
    return ds;
  endfunction

  // Request the bus (SBR_n), grant it gdly cycles after BR_n appears.
  task automatic arbitrate(input int gdly);
    SBR_n = 1'b0;
    tick(); tick();
    chk("br_early", 32'(BR_n), 1);
    tick();
    chk("br_latency", 32'(BR_n), 0);
    chk("bm_in_req", 32'(BMASTER), 0);
    repeat (gdly) tick();
    BG_n = 1'b0;
    tick(); tick();
    chk("bm_early", 32'(BMASTER), 0);
    tick();
    chk("bm_latency", 32'(BMASTER), 1);
    chk("sbg_latency", 32'(SBG_n), 0);
    chk("br_own", 32'(BR_n), 0);
  endtask

  task automatic release_bus();
    SBR_n = 1'b1;
    tick(); tick();
    chk("rel_bm_held", 32'(BMASTER), 1);
    tick(); tick();
    chk("rel_outs", 32'(outs), 32'(RST_OUTS));
    BG_n = 1'b1;
  endtask

  // One Zorro III master cycle, started from OWN (or, with pre, already in
  // ADDR after a back-to-back strobe). mode: 0 DTACK, 1 BERR+DTACK together,
  // 2 no response. DTACK_n is asserted dly cycles after DATA entry and held
  // for hold cycles. keep_as leaves SAS_n low and checks the next FCS_n;
  // drop negates SBR_n during DATA and checks the deferred release.
  task automatic xfer(input logic rd, input logic [1:0] siz, input logic [1:0] sa,
                      input int mode, input int dly, input int hold,
                      input bit keep_as, input bit pre, input bit drop);
    int s, e, term_exp, own_exp, end_cyc;
    int n_st, n_tea, t_st, t_tea, t_re, t_rel;
    bit hi_seen;
    if (pre) begin
      s = cyc - 3;
    end else begin
      s = cyc;
      SREAD = rd; SSIZ = siz; SA = sa; SAS_n = 1'b0;
      tick(); tick();
      chk("fcs_early", 32'(FCS_n), 1);
      tick();
    end
    chk("addr_fcs", 32'(FCS_n), 0);
    chk("addr_ds", 32'(DS_n), 32'h0F);
    chk("addr_read", 32'(READ_O), 32'(rd));
    if (!keep_as) SAS_n = 1'b1;
    e = s + 4 + dly;
    if (mode == 2) begin
      term_exp = s + 4 + TO + 1;
      own_exp  = term_exp + 1 + REC;
    end else begin
      term_exp = e + 3;
      own_exp  = imax(term_exp + 1 + REC, e + hold + 3);
    end
    end_cyc = own_exp + 3;
    n_st = 0; n_tea = 0; t_st = -1; t_tea = -1; t_re = -1; t_rel = -1;
    hi_seen = 1'b0;
    while (cyc < end_cyc) begin
      tick();
      if (cyc == s + 4) begin
        chk("data_ds", 32'(DS_n), 32'(exp_ds(sa, siz)));
        chk("data_doe", 32'(DOE_O), 1);
        chk("data_read", 32'(READ_O), 32'(rd));
        chk("data_fcs", 32'(FCS_n), 0);
        if (drop) SBR_n = 1'b1;
      end
      if (mode != 2 && cyc == e) begin
        DTACK_n = 1'b0;
        BERR_n  = (mode == 1) ? 1'b0 : 1'b1;
      end
      if (mode != 2 && cyc == e + hold) begin
        DTACK_n = 1'b1;
        BERR_n  = 1'b1;
      end
      if (!STERM_n) begin n_st++;  if (t_st  < 0) t_st  = cyc; end
      if (!TEA_n)   begin n_tea++; if (t_tea < 0) t_tea = cyc; end
      if (cyc == term_exp) begin
        chk("term_fcs", 32'(FCS_n), 1);
        chk("term_ds", 32'(DS_n), 32'h0F);
        chk("term_doe", 32'(DOE_O), 0);
        chk("term_bm", 32'(BMASTER), 1);
      end
      if (!BMASTER && t_rel < 0) t_rel = cyc;
      if (cyc > s + 4 && FCS_n) hi_seen = 1'b1;
      if (keep_as && hi_seen && !FCS_n) begin
        t_re = cyc;
        break;
      end
    end
    if (mode == 0) begin
      chk("sterm_pulses", 32'(n_st), 1);
      chk("sterm_time", 32'(t_st), 32'(term_exp));
      chk("tea_pulses", 32'(n_tea), 0);
    end else begin
      chk("tea_pulses", 32'(n_tea), 1);
      chk("tea_time", 32'(t_tea), 32'(term_exp));
      chk("sterm_pulses", 32'(n_st), 0);
    end
    if (keep_as) chk("b2b_fcs_time", 32'(t_re), 32'(own_exp + 1));
    if (drop) chk("drop_release_time", 32'(t_rel), 32'(own_exp + 1));
    else      chk("bm_held", 32'(t_rel), 32'(-1));
  endtask

  initial begin
    int pulses, mode, dly, hold;
    IORST_n = 1'b0; SBR_n = 1'b1; SAS_n = 1'b1; SREAD = 1'b0;
    SSIZ = 2'b00; SA = 2'b00; BG_n = 1'b1; DTACK_n = 1'b1; BERR_n = 1'b1;
    #1;
    chk("reset_outs", 32'(outs), 32'(RST_OUTS));
    tick(); tick();
    chk("reset_outs_clk", 32'(outs), 32'(RST_OUTS));
    IORST_n = 1'b1;
    tick(); tick();
    chk("idle_outs", 32'(outs), 32'(RST_OUTS));

    arbitrate(5);

    // Longword read, acknowledged 4 cycles into DATA.
    xfer(1'b1, 2'b00, 2'b00, 0, 4, 2, 1'b0, 1'b0, 1'b0);

    // Every SA/SSIZ combination.
    for (int i = 0; i < 16; i++)
      xfer(1'($urandom), 2'(i), 2'(i >> 2), 0, 0, 1, 1'b0, 1'b0, 1'b0);

    // BERR_n and DTACK_n together, then no response at all.
    xfer(1'b0, 2'b00, 2'b00, 1, 2, 2, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 2'b10, 2'b10, 2, 0, 1, 1'b0, 1'b0, 1'b0);

    // Back-to-back writes with SAS_n held low: recovery-bound and
    // DTACK-release-bound spacing.
    xfer(1'b0, 2'b00, 2'b00, 0, 1, 1, 1'b1, 1'b0, 1'b0);
    xfer(1'b0, 2'b00, 2'b00, 0, 2, 3, 1'b0, 1'b1, 1'b0);
    xfer(1'b0, 2'b01, 2'b11, 0, 0, 5, 1'b1, 1'b0, 1'b0);
    xfer(1'b0, 2'b01, 2'b11, 0, 1, 1, 1'b0, 1'b1, 1'b0);

    // Random transfers; BG_n wanders to show a withdrawn grant is ignored.
    for (int i = 0; i < 14; i++) begin
      BG_n = 1'($urandom);
      mode = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      dly  = int'($urandom_range(0, 5));
      hold = int'($urandom_range(1, 6));
      xfer(1'($urandom), 2'($urandom), 2'($urandom), mode, dly, hold,
           1'b0, 1'b0, 1'b0);
    end
    BG_n = 1'b0;

    // SBR_n withdrawn during DATA: cycle finishes, then the bus is released.
    xfer(1'b1, 2'b00, 2'b01, 0, 1, 2, 1'b0, 1'b0, 1'b1);
    BG_n = 1'b1;
    tick(); tick();
    chk("after_drop_outs", 32'(outs), 32'(RST_OUTS));
    arbitrate(3);
    release_bus();
    tick();
    arbitrate(2);

    // Reset in the middle of DATA with an acknowledge pending.
    SREAD = 1'b1; SSIZ = 2'b00; SA = 2'b00; SAS_n = 1'b0;
    repeat (4) tick();
    chk("pre_reset_doe", 32'(DOE_O), 1);
    IORST_n = 1'b0;
    DTACK_n = 1'b0;
    #1;
    chk("reset_async_outs", 32'(outs), 32'(RST_OUTS));
    SBR_n = 1'b1; SAS_n = 1'b1; BG_n = 1'b1;
    tick(); tick();
    IORST_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      tick();
      if (!STERM_n || !TEA_n) pulses++;
    end
    chk("post_reset_pulses", 32'(pulses), 0);
    chk("post_reset_outs", 32'(outs), 32'(RST_OUTS));
    DTACK_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
